// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 digest reader: widths, the reader
// state encoding and the SHA-256 initial hash values H0..H7.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int DIGEST_W  = WORD_W * NUM_WORDS;
  localparam int CNT_W     = $clog2(NUM_WORDS);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } reader_state_e;

  // SHA-256 initial hash state, H0 in the top word.
  localparam logic [DIGEST_W-1:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endpackage

// File: rtl/sha256_digest_buf.sv
// Eight-word digest buffer: parallel load of the full hash state (H0 to
// word 0), combinational indexed read, and a per-word clear used to wipe
// words as they are read out.
module sha256_digest_buf
  import sha256_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_en_i,
  input  logic [DIGEST_W-1:0]  load_data_i,
  input  logic                 clr_en_i,
  input  logic [CNT_W-1:0]     clr_idx_i,
  input  logic [CNT_W-1:0]     rd_idx_i,
  output logic [WORD_W-1:0]    rd_data_o
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];

  // Word storage: load has priority; load and clear never coincide in use.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (load_en_i) begin
      for (int i = 0; i < NUM_WORDS; i++)
        mem_q[i] <= load_data_i[DIGEST_W-1-i*WORD_W -: WORD_W];
    end else if (clr_en_i) begin
      mem_q[clr_idx_i] <= '0;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sha256_digest_reader.sv
// SHA-256 digest reader: captures the 256-bit hash state in one cycle and
// streams it out H0..H7 as 32-bit words over valid/ready.
// Build option SHA_DIGEST_ZEROIZE_EN: wipe each buffer word as it transfers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no digest in flight; data_o=0, valid_o=0; waits for load_i
// SEND  | valid_o=1, data_o=buffer[cnt]; advances on each transfer
module sha256_digest_reader
  import sha256_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_i,
  input  logic [DIGEST_W-1:0]  digest_i,
  output logic                 busy_o,
  output logic [WORD_W-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic                 done_o
);

  reader_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic [WORD_W-1:0] next_word;
  logic              capture;
  logic              xfer;
  logic              clr_en;

  assign cnt_d   = cnt_q + 1'b1;
  assign capture = (state_q == IDLE) && load_i;
  assign xfer    = (state_q == SEND) && ready_i;

`ifdef SHA_DIGEST_ZEROIZE_EN
  assign clr_en = xfer;
`else
  assign clr_en = 1'b0;
`endif

  sha256_digest_buf u_buf (
    .CLK         (CLK),
    .RST         (RST),
    .load_en_i   (capture),
    .load_data_i (digest_i),
    .clr_en_i    (clr_en),
    .clr_idx_i   (cnt_q),
    .rd_idx_i    (cnt_d),
    .rd_data_o   (next_word)
  );

  // Reader FSM with registered outputs; the next word is prefetched from
  // the buffer so data_o is already valid on the cycle after a transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_i) begin
            state_q <= SEND;
            cnt_q   <= '0;
            data_q  <= digest_i[DIGEST_W-1 -: WORD_W];
            valid_q <= 1'b1;
            last_q  <= (LAST_IDX == '0);
          end
        end
        SEND: begin
          if (ready_i) begin
            if (cnt_q == LAST_IDX) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              data_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q  <= cnt_d;
              data_q <= next_word;
              last_q <= (cnt_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == SEND);
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader. Inputs change and outputs are
// sampled on the falling edge of CLK.
module tb_sha256_digest_reader;
  import sha256_pkg::*;

  localparam logic [255:0] ABC_DG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] ONES_DG = {256{1'b1}};

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         load_i = 1'b0;
  logic [255:0] digest_i = '0;
  logic         busy_o;
  logic [31:0]  data_o;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic         last_o;
  logic         done_o;

  int n_pass  = 0;
  int n_total = 0;

  sha256_digest_reader u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .load_i   (load_i),
    .digest_i (digest_i),
    .busy_o   (busy_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o),
    .done_o   (done_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] wd(input logic [255:0] dg, input int i);
    logic [255:0] sh;
    sh = dg << (32 * i);
    return sh[255:224];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o},  32'd0);
    chk({tag, "_last"},  {31'd0, last_o},  32'd0);
    chk({tag, "_data"},  data_o,           32'd0);
  endtask

  // Request a capture on the next rising edge.
  task automatic start(input logic [255:0] dg);
    load_i   = 1'b1;
    digest_i = dg;
  endtask

  // Stream 8 words with ready high, optionally pulsing load at word inj,
  // then check the done cycle and optionally request the next capture.
  task automatic run(input string tag, input logic [255:0] dg, input int inj,
                     input bit nxt, input logic [255:0] nxt_dg);
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      load_i = 1'b0;
      chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      chk({tag, "_busy"},  {31'd0, busy_o},  32'd1);
      chk({tag, "_data"},  data_o,           wd(dg, i));
      chk({tag, "_last"},  {31'd0, last_o},  {31'd0, (i == 7)});
      chk({tag, "_nodone"}, {31'd0, done_o}, 32'd0);
      if (i == inj) begin
        load_i   = 1'b1;
        digest_i = ONES_DG;
      end
    end
    @(negedge CLK);
    load_i = 1'b0;
    chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
    chk_idle({tag, "_end"});
    if (nxt) start(nxt_dg);
  endtask

  logic [3:0]  pat = 4'b1001;
  int          n_x;
  bit          got_done;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  initial begin
    // Reset state
    #2;
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk_idle("rst");
    chk("rst_buf0", u_dut.u_buf.mem_q[0], 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    ready_i = 1'b1;
    @(negedge CLK);
    chk_idle("idle_ready_ignored");

    // "abc" digest with ready held high
    start(ABC_DG);
    run("abc", ABC_DG, -1, 1'b0, '0);
    @(negedge CLK);
    chk("abc_done_pulse", {31'd0, done_o}, 32'd0);

    // Buffer contents after a full readout
    for (int i = 0; i < 8; i++) begin
`ifdef SHA_DIGEST_ZEROIZE_EN
      chk("buf_after_read", u_dut.u_buf.mem_q[i], 32'd0);
`else
      chk("buf_after_read", u_dut.u_buf.mem_q[i], wd(ABC_DG, i));
`endif
    end

    // Backpressure with ready pattern 1,0,0,1
    start(H_INIT);
    @(negedge CLK);
    load_i = 1'b0;
    n_x = 0;
    got_done = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    for (int c = 0; c < 64 && !got_done; c++) begin
      if (done_o) begin
        got_done = 1'b1;
        chk("bp_count", n_x, 32'd8);
        chk_idle("bp_end");
      end else begin
        if (prev_stall) begin
          chk("bp_stall_data", data_o, prev_data);
          chk("bp_stall_last", {31'd0, last_o}, {31'd0, prev_last});
        end
        chk("bp_valid", {31'd0, valid_o}, 32'd1);
        chk("bp_data", data_o, wd(H_INIT, n_x));
        chk("bp_last", {31'd0, last_o}, {31'd0, (n_x == 7)});
        ready_i    = pat[c % 4];
        prev_stall = !ready_i;
        prev_data  = data_o;
        prev_last  = last_o;
        if (ready_i) n_x++;
        @(negedge CLK);
      end
    end
    chk("bp_done_seen", {31'd0, got_done}, 32'd1);
    ready_i = 1'b1;

    // Load during SEND is ignored
    start(ABC_DG);
    run("ldsend", ABC_DG, 3, 1'b0, '0);
    @(negedge CLK);
    chk_idle("ldsend_after");

    // Back-to-back: reload in the done cycle
    start(ABC_DG);
    run("b2b_a", ABC_DG, -1, 1'b1, EMPTY_DG);
    run("b2b_b", EMPTY_DG, -1, 1'b0, '0);

    // Reset mid-stream after word 4
    start(ABC_DG);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      load_i = 1'b0;
      chk("mid_data", data_o, wd(ABC_DG, i));
    end
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);
    chk_idle("mid_rst");
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_nodone", {31'd0, done_o}, 32'd0);
      chk("mid_novalid", {31'd0, valid_o}, 32'd0);
    end
    start(EMPTY_DG);
    run("fresh", EMPTY_DG, -1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
